// File: rtl/imuldiv_muldiv_dispatch.sv
// Multiply/divide dispatcher: accepts one muldiv request, forwards it to the multiplier or
// divider, and returns the selected 32-bit word. Optional macro: IMULDIV_DIV_ZERO_BYPASS_EN.
module imuldiv_muldiv_dispatch (
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  muldivreq_msg_fn,
  input  logic [31:0] muldivreq_msg_a,
  input  logic [31:0] muldivreq_msg_b,
  input  logic        muldivreq_val,
  output logic        muldivreq_rdy,

  output logic [31:0] mulreq_msg_a,
  output logic [31:0] mulreq_msg_b,
  output logic        mulreq_val,
  input  logic        mulreq_rdy,

  input  logic [63:0] mulresp_msg_result,
  input  logic        mulresp_val,
  output logic        mulresp_rdy,

  output logic        divreq_msg_fn,
  output logic [31:0] divreq_msg_a,
  output logic [31:0] divreq_msg_b,
  output logic        divreq_val,
  input  logic        divreq_rdy,

  input  logic [63:0] divresp_msg_result,
  input  logic        divresp_val,
  output logic        divresp_rdy,

  output logic [31:0] muldivresp_msg_result,
  output logic        muldivresp_val,
  input  logic        muldivresp_rdy
);

  localparam logic [2:0] FN_MUL  = 3'd0;
  localparam logic [2:0] FN_DIV  = 3'd1;
  localparam logic [2:0] FN_DIVU = 3'd2;
  localparam logic [2:0] FN_REM  = 3'd3;
  localparam logic [2:0] FN_REMU = 3'd4;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic [2:0]  fn_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] result_q;

  logic is_mul, is_div, is_rem, is_signed, div_bypass, use_div;
  logic unused_mul_hi;

  assign is_mul    = (fn_q == FN_MUL);
  assign is_div    = (fn_q == FN_DIV) || (fn_q == FN_DIVU) || (fn_q == FN_REM) || (fn_q == FN_REMU);
  assign is_rem    = (fn_q == FN_REM) || (fn_q == FN_REMU);
  assign is_signed = (fn_q == FN_DIV) || (fn_q == FN_REM);

`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
  assign div_bypass = is_div && (b_q == 32'd0);
`else
  assign div_bypass = 1'b0;
`endif
  assign use_div = is_div && !div_bypass;

  // Only the low product word is ever returned.
  assign unused_mul_hi = ^mulresp_msg_result[63:32];

  assign muldivreq_rdy         = (state == IDLE);
  assign mulreq_val            = (state == ISSUE) && is_mul;
  assign divreq_val            = (state == ISSUE) && use_div;
  assign mulresp_rdy           = (state == WAIT) && is_mul;
  assign divresp_rdy           = (state == WAIT) && use_div;
  assign muldivresp_val        = (state == RESP);
  assign muldivresp_msg_result = result_q;

  assign mulreq_msg_a  = a_q;
  assign mulreq_msg_b  = b_q;
  assign divreq_msg_a  = a_q;
  assign divreq_msg_b  = b_q;
  assign divreq_msg_fn = is_signed;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      fn_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      result_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (muldivreq_val) begin
            fn_q  <= muldivreq_msg_fn;
            a_q   <= muldivreq_msg_a;
            b_q   <= muldivreq_msg_b;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          if (is_mul) begin
            if (mulreq_rdy) state <= WAIT;
          end else if (use_div) begin
            if (divreq_rdy) state <= WAIT;
          end else begin
            // Illegal fn returns 0; bypassed divide-by-zero returns all-ones or the dividend.
            result_q <= div_bypass ? (is_rem ? a_q : 32'hFFFF_FFFF) : 32'd0;
            state    <= RESP;
          end
        end
        WAIT: begin
          if (is_mul && mulresp_val) begin
            result_q <= mulresp_msg_result[31:0];
            state    <= RESP;
          end else if (use_div && divresp_val) begin
            result_q <= is_rem ? divresp_msg_result[63:32] : divresp_msg_result[31:0];
            state    <= RESP;
          end
        end
        RESP: begin
          if (muldivresp_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// Directed bench for imuldiv_muldiv_dispatch: bench acts as both units, expected results
// come from a scoreboard queue filled when each request is driven.
module tb_imuldiv_muldiv_dispatch;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val, muldivreq_rdy;
  logic [31:0] mulreq_msg_a, mulreq_msg_b;
  logic        mulreq_val, mulreq_rdy;
  logic [63:0] mulresp_msg_result;
  logic        mulresp_val, mulresp_rdy;
  logic        divreq_msg_fn;
  logic [31:0] divreq_msg_a, divreq_msg_b;
  logic        divreq_val, divreq_rdy;
  logic [63:0] divresp_msg_result;
  logic        divresp_val, divresp_rdy;
  logic [31:0] muldivresp_msg_result;
  logic        muldivresp_val, muldivresp_rdy;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  imuldiv_muldiv_dispatch dut (
    .clk(clk), .reset(reset),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val), .muldivreq_rdy(muldivreq_rdy),
    .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
    .mulreq_rdy(mulreq_rdy),
    .mulresp_msg_result(mulresp_msg_result), .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
    .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
    .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
    .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val), .divresp_rdy(divresp_rdy),
    .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
    .muldivresp_rdy(muldivresp_rdy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // tgt: 0 = no unit (illegal or bypassed), 1 = multiplier, 2 = divider
  task automatic run_op(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] unit_res, input int req_stall, input int resp_stall);
    logic [31:0] exp;
    logic [31:0] got;
    int tgt;
    tgt = (fn == 3'd0) ? 1 : (fn <= 3'd4) ? 2 : 0;
`ifdef IMULDIV_DIV_ZERO_BYPASS_EN
    if (tgt == 2 && b == 32'd0) tgt = 0;
`endif
    if (fn == 3'd0)                    exp = unit_res[31:0];
    else if (fn == 3'd1 || fn == 3'd2) exp = (tgt == 2) ? unit_res[31:0] : 32'hFFFF_FFFF;
    else if (fn == 3'd3 || fn == 3'd4) exp = (tgt == 2) ? unit_res[63:32] : a;
    else                               exp = 32'd0;
    sb.push_back(exp);

    check("idle_req_rdy", muldivreq_rdy, 1);
    check("idle_resp_val", muldivresp_val, 0);
    muldivreq_val = 1'b1; muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b;
    @(negedge clk);
    // Scramble inputs so the checks below prove the operands were latched.
    muldivreq_val = 1'b0; muldivreq_msg_fn = 3'd7; muldivreq_msg_a = ~a; muldivreq_msg_b = ~b;
    check("issue_req_rdy", muldivreq_rdy, 0);
    check("issue_mulreq_val", mulreq_val, (tgt == 1));
    check("issue_divreq_val", divreq_val, (tgt == 2));
    if (tgt == 1) begin
      check("mul_a", mulreq_msg_a, a);
      check("mul_b", mulreq_msg_b, b);
    end else if (tgt == 2) begin
      check("div_a", divreq_msg_a, a);
      check("div_b", divreq_msg_b, b);
      check("div_fn", divreq_msg_fn, (fn == 3'd1 || fn == 3'd3));
    end

    if (tgt != 0) begin
      repeat (req_stall) begin
        @(negedge clk);
        check("stall_val", (tgt == 1) ? mulreq_val : divreq_val, 1);
        check("stall_a", (tgt == 1) ? mulreq_msg_a : divreq_msg_a, a);
        check("stall_b", (tgt == 1) ? mulreq_msg_b : divreq_msg_b, b);
        check("stall_req_rdy", muldivreq_rdy, 0);
      end
      if (tgt == 1) mulreq_rdy = 1'b1; else divreq_rdy = 1'b1;
      @(negedge clk);
      mulreq_rdy = 1'b0; divreq_rdy = 1'b0;
      check("wait_mulresp_rdy", mulresp_rdy, (tgt == 1));
      check("wait_divresp_rdy", divresp_rdy, (tgt == 2));
      check("wait_no_req_val", {mulreq_val, divreq_val}, 2'b00);
      check("wait_req_rdy", muldivreq_rdy, 0);
      // A response from the other unit must be ignored.
      if (tgt == 1) begin divresp_val = 1'b1; divresp_msg_result = 64'hBAD0_BAD1_BAD2_BAD3; end
      else begin mulresp_val = 1'b1; mulresp_msg_result = 64'hBAD0_BAD1_BAD2_BAD3; end
      @(negedge clk);
      divresp_val = 1'b0; mulresp_val = 1'b0;
      check("ignore_other_resp", muldivresp_val, 0);
      if (tgt == 1) begin mulresp_val = 1'b1; mulresp_msg_result = unit_res; end
      else begin divresp_val = 1'b1; divresp_msg_result = unit_res; end
      @(negedge clk);
      divresp_val = 1'b0; mulresp_val = 1'b0;
    end else begin
      @(negedge clk);
    end

    check("resp_val", muldivresp_val, 1);
    if (sb.size() == 0) begin
      check("sb_underflow", 1, 0);
      got = 32'd0;
    end else begin
      got = sb.pop_front();
    end
    check("resp_result", muldivresp_msg_result, got);
    repeat (resp_stall) begin
      muldivreq_val = 1'b1;
      @(negedge clk);
      check("resp_hold_val", muldivresp_val, 1);
      check("resp_hold_result", muldivresp_msg_result, got);
      check("resp_req_rdy", muldivreq_rdy, 0);
    end
    muldivresp_rdy = 1'b1;
    @(negedge clk);
    muldivresp_rdy = 1'b0; muldivreq_val = 1'b0;
    check("post_resp_val", muldivresp_val, 0);
    check("post_req_rdy", muldivreq_rdy, 1);
  endtask

  initial begin
    reset = 1'b1;
    muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd0; muldivreq_msg_b = 32'd0; muldivreq_val = 1'b0;
    mulreq_rdy = 1'b0; mulresp_msg_result = 64'd0; mulresp_val = 1'b0;
    divreq_rdy = 1'b0; divresp_msg_result = 64'd0; divresp_val = 1'b0;
    muldivresp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check("rst_req_rdy", muldivreq_rdy, 1);
    check("rst_vals", {mulreq_val, divreq_val, muldivresp_val}, 3'b000);
    check("rst_resp_rdys", {mulresp_rdy, divresp_rdy}, 2'b00);
    check("rst_result", muldivresp_msg_result, 32'd0);

    run_op(3'd0, 32'd3, 32'd5, 64'd15, 0, 0);
    run_op(3'd1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0, 0);
    run_op(3'd4, 32'd7, 32'd0, {32'hDEAD_0001, 32'h1234_5678}, 0, 0);
    run_op(3'd2, 32'd100, 32'd7, {32'd2, 32'd14}, 4, 0);
    run_op(3'd0, 32'h0001_0000, 32'h0003_0000, 64'h0000_0003_0000_0000, 1, 3);
    run_op(3'd5, 32'd9, 32'd9, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1);
    run_op(3'd1, 32'd42, 32'd0, {32'd42, 32'hFFFF_FFFF}, 0, 0);

    // Reset while waiting on the divider with its response arriving.
    muldivreq_val = 1'b1; muldivreq_msg_fn = 3'd1; muldivreq_msg_a = 32'd50; muldivreq_msg_b = 32'd5;
    @(negedge clk);
    muldivreq_val = 1'b0;
    divreq_rdy = 1'b1;
    @(negedge clk);
    divreq_rdy = 1'b0;
    check("rw_in_wait", divresp_rdy, 1);
    divresp_val = 1'b1; divresp_msg_result = {32'd0, 32'd10}; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; divresp_val = 1'b0;
    check("rw_req_rdy", muldivreq_rdy, 1);
    check("rw_resp_val", muldivresp_val, 0);
    check("rw_divresp_rdy", divresp_rdy, 0);
    check("rw_result", muldivresp_msg_result, 32'd0);
    @(negedge clk);
    check("rw_no_stale", muldivresp_val, 0);

    run_op(3'd0, 32'd6, 32'd7, 64'd42, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imuldiv_muldiv_dispatch.md
IMULDIV_MULDIV_DISPATCH -- requirements
Module: imuldiv_muldiv_dispatch

Interface
REQ-001 SHALL have ports: clk in 1, clock; reset in 1, synchronous, active-high.
REQ-002 SHALL have muldivreq_msg_fn in 3: 0 MUL, 1 DIV, 2 DIVU, 3 REM, 4 REMU, 5-7 illegal.
REQ-003 SHALL have muldivreq_msg_a and muldivreq_msg_b, each in 32, operands; muldivreq_val in 1; muldivreq_rdy out 1.
REQ-004 SHALL have mulreq_msg_a and mulreq_msg_b, each out 32; mulreq_val out 1; mulreq_rdy in 1.
REQ-005 SHALL have mulresp_msg_result in 64, product with low word in [31:0]; mulresp_val in 1; mulresp_rdy out 1.
REQ-006 SHALL have divreq_msg_fn out 1 (1 = signed), divreq_msg_a and divreq_msg_b, each out 32; divreq_val out 1; divreq_rdy in 1.
REQ-007 SHALL have divresp_msg_result in 64, {remainder[63:32], quotient[31:0]}; divresp_val in 1; divresp_rdy out 1.
REQ-008 SHALL have muldivresp_msg_result out 32; muldivresp_val out 1; muldivresp_rdy in 1.

Function
REQ-009 SHALL implement FSM IDLE, ISSUE, WAIT, RESP with one operation outstanding at a time.
REQ-010 IDLE: muldivreq_rdy=1 and no other val/rdy asserted; on muldivreq_val, latch fn/a/b into registers and go to ISSUE.
REQ-011 ISSUE: drive the target unit's req_val=1 with the registered operands; divreq_msg_fn=1 for DIV/REM and 0 for DIVU/REMU.
REQ-012 ISSUE exit: on target req_rdy=1 in the same cycle, go to WAIT; otherwise hold val and operands stable.
REQ-013 WAIT: assert only the target unit's resp_rdy; on target resp_val, capture the selected word into the result register and go to RESP.
REQ-014 Word select: MUL takes [31:0] of mulresp; DIV/DIVU take [31:0] of divresp; REM/REMU take [63:32] of divresp.
REQ-015 Illegal fn: ISSUE goes directly to RESP with result 0; no unit val is asserted.
REQ-016 RESP: muldivresp_val=1 and muldivresp_msg_result = result register; on muldivresp_rdy, go to IDLE.
REQ-017 Minimum latency from request accept to muldivresp_val is 2 cycles plus unit latency; no request is accepted outside IDLE.
REQ-018 A response from the non-target unit SHALL be ignored; its resp_rdy stays 0.
REQ-019 All outputs SHALL be driven from registers or state decode, with no combinational path from muldivresp_rdy to muldivreq_rdy.

Reset
REQ-020 Reset SHALL force state to IDLE and clear the fn, a, b and result registers to 0.
REQ-021 After reset: all val and resp_rdy outputs are 0, muldivreq_rdy is 1, and muldivresp_msg_result is 0.
REQ-022 Reset in any state SHALL abandon the operation; the in-flight unit is reset by the same reset, and no stale response is delivered.

Configuration
REQ-023 Macro IMULDIV_DIV_ZERO_BYPASS_EN, when defined: DIV/DIVU/REM/REMU with b==0 SHALL go directly from ISSUE to RESP without asserting divreq_val.
REQ-024 With IMULDIV_DIV_ZERO_BYPASS_EN defined, divide-by-zero results SHALL be 0xFFFFFFFF for DIV/DIVU and a for REM/REMU.
REQ-025 Without IMULDIV_DIV_ZERO_BYPASS_EN: divide-by-zero SHALL be issued to the divider, and the divider's result is returned unmodified.

Verification
REQ-026 MUL a=3, b=5, multiplier returns 64'd15 -> muldivresp_msg_result=15; divreq_val never asserted.
REQ-027 DIV a=0xFFFFFFF9, b=2, divider returns {0xFFFFFFFF, 0xFFFFFFFD} -> divreq_msg_fn=1 and result=0xFFFFFFFD; same operands with REM -> 0xFFFFFFFF.
REQ-028 REMU a=7, b=0 with macro defined -> result=7 and divreq_val stays 0; without macro -> divreq_val=1 and the divider result's high word is returned.
REQ-029 DIVU with divreq_rdy held 0 for 4 cycles -> divreq_val and operands stable for 4 cycles, then issue completes; muldivreq_rdy=0 throughout.
REQ-030 muldivresp_rdy=0 for 3 cycles in RESP -> result and val held; a new muldivreq_val is not accepted until the cycle after the handshake.
REQ-031 Reset asserted in WAIT with divresp_val=1 -> next cycle state IDLE, muldivresp_val=0, muldivreq_rdy=1.
